bridge_rx: RTL

BRIDGE_RX -- requirements
Module: bridge_rx

---
 rtl/bridge_rx.sv | 115 +++++++++++
 1 files changed

// File: rtl/bridge_rx.sv
// ASCII command parser: turns "R"+4 hex / "W"+8 hex + CR|LF byte streams from a UART
// receiver into single-cycle bus read/write requests with registered outputs.
module bridge_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic [15:0] addr_o,
  output logic [15:0] data_o,
  output logic        rw_o,
  output logic        valid_o,
  output logic        error_o
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [15:0] addr_q, addr_d, data_q, data_d;
  logic        rw_q, rw_d, valid_q, valid_d, error_q, error_d;

  logic        is_hex, is_term, is_rd, is_wr;
  logic [3:0]  nib, limit;

  // Byte classification
  always_comb begin
    is_hex = 1'b1;
    nib    = 4'd0;
    if (data_i >= 8'h30 && data_i <= 8'h39) begin
      nib = data_i[3:0];
    end else if ((data_i >= 8'h41 && data_i <= 8'h46) ||
                 (data_i >= 8'h61 && data_i <= 8'h66)) begin
      nib = data_i[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
    is_term = (data_i == 8'h0d) || (data_i == 8'h0a);
    is_rd   = (data_i == 8'h52) || (data_i == 8'h72);
    is_wr   = (data_i == 8'h57) || (data_i == 8'h77);
    limit   = (state_q == StWrite) ? 4'd8 : 4'd4;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    if (valid_i) begin
      // A command letter always restarts parsing, abandoning any partial message.
      if (is_rd) begin
        state_d = StRead;
        cnt_d   = 4'd0;
        buf_d   = 32'd0;
      end else if (is_wr) begin
        state_d = StWrite;
        cnt_d   = 4'd0;
        buf_d   = 32'd0;
      end else if (state_q != StIdle) begin
        if (is_hex && cnt_q < limit) begin
          buf_d = {buf_q[27:0], nib};
          cnt_d = cnt_q + 4'd1;
        end else if (is_term && cnt_q == limit) begin
          state_d = StIdle;
          valid_d = 1'b1;
          if (state_q == StWrite) begin
            rw_d   = 1'b1;
            addr_d = buf_q[31:16];
            data_d = buf_q[15:0];
          end else begin
            rw_d   = 1'b0;
            addr_d = buf_q[15:0];
            data_d = 16'd0;
          end
        end else begin
          state_d = StIdle;
          error_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      buf_q   <= 32'd0;
      addr_q  <= 16'd0;
      data_q  <= 16'd0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign rw_o    = rw_q;
  assign valid_o = valid_q;
  assign error_o = error_q;

endmodule
